ff_unstuff_reader: RTL and testbench
====================================

Name: ff_unstuff_reader

Overview:
- Read-side counterpart of the entropy-stream byte stuffer.
- Fetches a stuffed byte stream from the 32-bit scratch SRAM, starting at a base word address, for a given stuffed-byte length.
- Drops each 0x00 that follows a 0xFF and repacks the surviving bytes big-endian into 32-bit words.
- Delivers those words over a valid/ready stream to the downstream Huffman decoder, flagging the final partial word.

Parameters:
- ADDR_W, 12: SRAM word address width.
- CNT_W, 14: width of the stuffed-byte count.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle job start; sampled only in IDLE
- base_addr  in  ADDR_W  first SRAM word address of the job
- byte_cnt  in  CNT_W  number of stuffed bytes stored in SRAM
- sram_addr  out  ADDR_W  SRAM read address
- sram_oe  out  1  SRAM read strobe; data is valid on sram_rdata one cycle later
- sram_rdata  in  32  SRAM read data; byte0 is [31:24]
- out_data  out  32  unstuffed word, big-endian, zero-padded
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accept
- out_last  out  1  final word of the job; qualified by out_valid
- out_nbytes  out  3  valid bytes in out_data, 1..4
- busy  out  1  job in progress
- done  out  1  one-cycle pulse when the job completes
- marker_err  out  1  sticky; a 0xFF was followed by a non-0x00 byte

Behaviour:
- Reset values: all outputs 0. Internal state → IDLE; remain counter, byte index, ff_pending and carry are cleared. A reset asserted mid-job aborts the job immediately; no done pulse is produced.
- States:
  - IDLE → FETCH on start when byte_cnt≠0. Latch base_addr and byte_cnt, clear marker_err, set busy.
  - IDLE → FIN on start when byte_cnt=0. No SRAM access and no output word.
  - FETCH: sram_oe=1 for one cycle with the current address, then → WAIT.
  - WAIT: capture sram_rdata into the word register, address+1, byte index=0, then → SCAN.
- SCAN, one byte per cycle:
  - Take byte[index]; remain−1.
  - If ff_pending and byte==0x00: drop the byte, clear ff_pending.
  - If ff_pending and byte≠0x00: set marker_err and keep the byte.
  - Otherwise: append the byte; set ff_pending when byte==0xFF.
- After each SCAN cycle, in priority order:
  - remain==0 → EMIT with last=1. If the assembled count is 0 (the only byte was a dropped 0x00), go → FIN instead, and the previous word must already have carried last (see deferral rule).
  - assembled==4 and not ff_pending → EMIT.
  - index==3 → FETCH.
  - else stay in SCAN.
- Deferral rule: a full word whose last byte is 0xFF with remain>0 is not emitted until the next byte is consumed. A dropped 0x00 then lets the word emit, with last set if remain is now 0. A non-0x00 byte goes into a 1-byte carry register that becomes byte0 of the next word.
- EMIT: out_valid=1. out_data/out_nbytes/out_last stay stable until out_ready. On the handshake:
  - last → FIN.
  - index==3 or word exhausted → FETCH.
  - else → SCAN.
  - Assembly is cleared and the carry is loaded if present.
- FIN: done=1 for one cycle, busy=0, → IDLE.
- A 0xFF as the final stuffed byte is kept; no error.
- Address increments modulo 2^ADDR_W.
- start outside IDLE is ignored.
- Throughput: at most 1 byte per cycle, plus 2 cycles of fetch overhead per SRAM word.

Optional Feature:
- Macro: FF_MARKER_STOP_EN.
- Defined: a 0xFF followed by a non-0x00 byte terminates the job.
  - The 0xFF and the marker byte are discarded.
  - The bytes already assembled are emitted with out_last=1. If none are assembled, an empty terminal word is sent (out_nbytes=0, out_last=1).
  - marker_err is set and remaining SRAM bytes are not read.
- Undefined: bytes pass through as described in Behaviour and marker_err is informational only.

Test Plan:
1. base=0x010, byte_cnt=5, mem[0x010]=0x12FF0034, mem[0x011]=0x56000000 → one word 0x12FF3456, nbytes=4, last=1. SRAM reads 0x010 then 0x011; done pulses once.
2. byte_cnt=6, words 0xAABBCCFF, 0x00DD0000 (FF/00 straddles a word boundary) → 0xAABBCCFF, nbytes=4, last=0; then 0xDD000000, nbytes=1, last=1.
3. Case 1 with out_ready held low for 10 cycles during EMIT → out_data/out_valid stable throughout; no extra SRAM read; completes after ready rises.
4. start with byte_cnt=0 → done pulse two cycles later; sram_oe and out_valid never asserted.
5. byte_cnt=4, word 0x11FFD922:
   - Without macro: 0x11FFD922, nbytes=4, marker_err=1.
   - With FF_MARKER_STOP_EN: 0x11000000, nbytes=1, last=1, marker_err=1.
6. rst pulsed while in EMIT of case 2 → all outputs 0 next edge; no done. A new start then executes case 1 correctly.

Source files
------------

// File: rtl/ff_unstuff_reader.sv
// Read-side byte unstuffer: fetches stuffed bytes from SRAM, drops the 0x00 after each 0xFF,
// repacks big-endian 32-bit words for the Huffman decoder. Option macro: FF_MARKER_STOP_EN.
module ff_unstuff_reader #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  byte_cnt,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_oe,
    input  logic [31:0]       sram_rdata,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [2:0]        out_nbytes,
    output logic              busy,
    output logic              done,
    output logic              marker_err
);
    // state  | meaning
    // IDLE   | waiting for start
    // FETCH  | SRAM read strobe for current word
    // WAIT   | capture SRAM data, advance address
    // SCAN   | consume one stuffed byte per cycle
    // EMIT   | hold output word until accepted
    // FIN    | done pulse, back to IDLE
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SCAN, S_EMIT, S_FIN} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_remain;
    logic [31:0]       r_word;
    logic [1:0]        r_idx;
    logic              r_wexh;
    logic [31:0]       r_asm;
    logic [2:0]        r_cnt;
    logic              r_ffp;
    logic              r_carry_v;
    logic [7:0]        r_carry;
    logic              r_last;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic [7:0]        w_byte;
    logic [CNT_W-1:0]  w_remain_n;
    logic [31:0]       w_asm_n;
    logic [2:0]        w_cnt_n;
    logic              w_ffp_n;
    logic              w_carry_v_n;
    logic [7:0]        w_carry_n;
    logic              w_err_n;
    logic              w_stop;
    logic              w_keep;
    logic [1:0]        w_pos;

    always_comb begin
        w_byte      = r_word[{~r_idx, 3'b000} +: 8];
        w_remain_n  = r_remain - CNT_W'(1);
        w_asm_n     = r_asm;
        w_cnt_n     = r_cnt;
        w_ffp_n     = r_ffp;
        w_carry_v_n = r_carry_v;
        w_carry_n   = r_carry;
        w_err_n     = r_err;
        w_stop      = 1'b0;
        w_keep      = 1'b0;
        w_pos       = r_cnt[1:0] - 2'd1;
        if (r_ffp && w_byte == 8'h00) begin
            w_ffp_n = 1'b0;
        end else begin
            if (r_ffp) w_err_n = 1'b1;
`ifdef FF_MARKER_STOP_EN
            // The 0xFF is always the newest assembled byte; strip it along with the marker.
            if (r_ffp) begin
                w_stop  = 1'b1;
                w_ffp_n = 1'b0;
                w_cnt_n = r_cnt - 3'd1;
                w_asm_n[{~w_pos, 3'b000} +: 8] = 8'h00;
            end else begin
                w_keep = 1'b1;
            end
`else
            w_keep = 1'b1;
`endif
        end
        if (w_keep) begin
            w_ffp_n = (w_byte == 8'hFF);
            if (r_cnt == 3'd4) begin
                w_carry_v_n = 1'b1;
                w_carry_n   = w_byte;
            end else begin
                w_asm_n[{~r_cnt[1:0], 3'b000} +: 8] = w_byte;
                w_cnt_n = r_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_remain  <= '0;
            r_word    <= '0;
            r_idx     <= '0;
            r_wexh    <= 1'b0;
            r_asm     <= '0;
            r_cnt     <= '0;
            r_ffp     <= 1'b0;
            r_carry_v <= 1'b0;
            r_carry   <= '0;
            r_last    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr    <= base_addr;
                        r_remain  <= byte_cnt;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_asm     <= '0;
                        r_cnt     <= '0;
                        r_ffp     <= 1'b0;
                        r_carry_v <= 1'b0;
                        r_last    <= 1'b0;
                        r_state   <= (byte_cnt != '0) ? S_FETCH : S_FIN;
                    end
                end
                S_FETCH: r_state <= S_WAIT;
                S_WAIT: begin
                    r_word  <= sram_rdata;
                    r_addr  <= r_addr + ADDR_W'(1);
                    r_idx   <= 2'd0;
                    r_state <= S_SCAN;
                end
                S_SCAN: begin
                    r_remain  <= w_remain_n;
                    r_asm     <= w_asm_n;
                    r_cnt     <= w_cnt_n;
                    r_ffp     <= w_ffp_n;
                    r_carry_v <= w_carry_v_n;
                    r_carry   <= w_carry_n;
                    r_err     <= w_err_n;
                    r_idx     <= r_idx + 2'd1;
                    r_wexh    <= (r_idx == 2'd3);
                    if (w_stop) begin
                        r_last  <= 1'b1;
                        r_state <= S_EMIT;
                    end else if (w_remain_n == '0) begin
                        // A pending carry needs one more word after this one.
                        r_last  <= !w_carry_v_n;
                        r_state <= (w_cnt_n == 3'd0) ? S_FIN : S_EMIT;
                    end else if (w_cnt_n == 3'd4 && (!w_ffp_n || w_carry_v_n)) begin
                        r_last  <= 1'b0;
                        r_state <= S_EMIT;
                    end else if (r_idx == 2'd3) begin
                        r_state <= S_FETCH;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        r_asm     <= r_carry_v ? {r_carry, 24'h0} : 32'h0;
                        r_cnt     <= r_carry_v ? 3'd1 : 3'd0;
                        r_carry_v <= 1'b0;
                        if (r_last)                     r_state <= S_FIN;
                        else if (r_carry_v && r_remain == '0) r_last <= 1'b1;
                        else if (r_wexh)                r_state <= S_FETCH;
                        else                            r_state <= S_SCAN;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_last  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sram_addr  = r_addr;
    assign sram_oe    = (r_state == S_FETCH);
    assign out_valid  = (r_state == S_EMIT);
    assign out_data   = r_asm;
    assign out_nbytes = r_cnt;
    assign out_last   = r_last;
    assign busy       = r_busy;
    assign done       = r_done;
    assign marker_err = r_err;
endmodule

// File: tb/tb_ff_unstuff_reader.sv
// Directed bench for ff_unstuff_reader: SRAM model, output scoreboard, assertion checks.
module tb_ff_unstuff_reader;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  byte_cnt = '0;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_oe;
    logic [31:0]       sram_rdata = '0;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_last;
    logic [2:0]        out_nbytes;
    logic              busy;
    logic              done;
    logic              marker_err;

    ff_unstuff_reader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .byte_cnt(byte_cnt),
        .sram_addr(sram_addr), .sram_oe(sram_oe), .sram_rdata(sram_rdata),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_nbytes(out_nbytes), .busy(busy), .done(done),
        .marker_err(marker_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  n;
        logic        l;
    } exp_t;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    exp_t              exp_q[$];
    logic [ADDR_W-1:0] rd_log[$];
    int done_cnt = 0, oe_cnt = 0, valid_cnt = 0;
    int n_pass = 0, n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    always @(posedge clk) if (sram_oe) sram_rdata <= mem[sram_addr];

    always @(negedge clk) begin
        exp_t e;
        if (sram_oe) begin
            oe_cnt++;
            rd_log.push_back(sram_addr);
        end
        if (done) done_cnt++;
        if (out_valid) valid_cnt++;
        if (out_valid && out_ready && !rst) begin
            chk("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_nbytes", 32'(out_nbytes), 32'(e.n));
                chk("out_last", 32'(out_last), 32'(e.l));
            end
        end
    end

    task automatic push_exp(input logic [31:0] d, input logic [2:0] n, input logic l);
        exp_t e;
        e.d = d; e.n = n; e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic run_job(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; byte_cnt = c;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int i = 0; i < 400 && done_cnt == d0; i++) @(posedge clk);
        chk({tag, "_done"}, done_cnt - d0, 1);
        repeat (4) @(posedge clk);
        chk({tag, "_single_done"}, done_cnt - d0, 1);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
        chk({tag, "_busy_low"}, 32'(busy), 0);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 200 && !out_valid; i++) @(negedge clk);
        chk({tag, "_reach_emit"}, 32'(out_valid), 1);
    endtask

    initial begin
        int d0, o0, v0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
        mem[12'h010] = 32'h12FF0034; mem[12'h011] = 32'h56000000;
        mem[12'h020] = 32'hAABBCCFF; mem[12'h021] = 32'h00DD0000;
        mem[12'h030] = 32'h11FFD922;
        mem[12'hFFF] = 32'h01020304; mem[12'h000] = 32'h05060708;

        #12;
        chk("rst_ctrl", {26'h0, sram_oe, out_valid, done, busy, out_last, marker_err}, 0);
        chk("rst_data", out_data, 0);
        chk("rst_nbytes_addr", {out_nbytes, sram_addr}, 0);
        @(negedge clk); rst = 1'b0;

        // case 1: FF/00 inside a word, job spans two SRAM words
        push_exp(32'h12FF3456, 3'd4, 1'b1);
        rd_log.delete(); d0 = done_cnt;
        run_job(12'h010, 14'd5);
        wait_done("c1", d0);
        chk("c1_reads", rd_log.size(), 2);
        if (rd_log.size() == 2) begin
            chk("c1_rd0", 32'(rd_log[0]), 32'h010);
            chk("c1_rd1", 32'(rd_log[1]), 32'h011);
        end
        chk("c1_err", 32'(marker_err), 0);

        // case 2: stuffing pair straddles a word boundary
        push_exp(32'hAABBCCFF, 3'd4, 1'b0);
        push_exp(32'hDD000000, 3'd1, 1'b1);
        d0 = done_cnt;
        run_job(12'h020, 14'd6);
        wait_done("c2", d0);

        // case 3: backpressure during EMIT
        push_exp(32'h12FF3456, 3'd4, 1'b1);
        rd_log.delete(); d0 = done_cnt;
        out_ready = 1'b0;
        run_job(12'h010, 14'd5);
        wait_valid("c3");
        o0 = oe_cnt;
        repeat (10) begin
            @(negedge clk);
            chk("c3_hold_valid", 32'(out_valid), 1);
            chk("c3_hold_data", out_data, 32'h12FF3456);
        end
        @(posedge clk);
        chk("c3_no_extra_read", oe_cnt - o0, 0);
        #1 out_ready = 1'b1;
        wait_done("c3", d0);
        chk("c3_reads", rd_log.size(), 2);

        // case 4: empty job
        d0 = done_cnt; o0 = oe_cnt; v0 = valid_cnt;
        run_job(12'h010, 14'd0);
        @(negedge clk); chk("c4_done_t1", 32'(done), 0);
        @(negedge clk); chk("c4_done_t2", 32'(done), 1);
        @(negedge clk); chk("c4_done_t3", 32'(done), 0);
        chk("c4_no_oe", oe_cnt - o0, 0);
        chk("c4_no_valid", valid_cnt - v0, 0);
        chk("c4_done_cnt", done_cnt - d0, 1);

        // case 5: 0xFF followed by a marker byte
`ifdef FF_MARKER_STOP_EN
        push_exp(32'h11000000, 3'd1, 1'b1);
`else
        push_exp(32'h11FFD922, 3'd4, 1'b1);
`endif
        d0 = done_cnt;
        run_job(12'h030, 14'd4);
        wait_done("c5", d0);
        chk("c5_err", 32'(marker_err), 1);

        // case 7: address wraps modulo 2^ADDR_W
        push_exp(32'h01020304, 3'd4, 1'b0);
        push_exp(32'h05060708, 3'd4, 1'b1);
        rd_log.delete(); d0 = done_cnt;
        run_job(12'hFFF, 14'd8);
        wait_done("c7", d0);
        chk("c7_reads", rd_log.size(), 2);
        if (rd_log.size() == 2) chk("c7_wrap", 32'(rd_log[1]), 32'h000);
        chk("c7_err_cleared", 32'(marker_err), 0);

        // case 6: reset during EMIT aborts without done, then a clean rerun
        out_ready = 1'b0;
        d0 = done_cnt;
        run_job(12'h020, 14'd6);
        wait_valid("c6");
        @(negedge clk); rst = 1'b1;
        exp_q.delete();
        #1;
        chk("c6_rst_ctrl", {26'h0, sram_oe, out_valid, done, busy, out_last, marker_err}, 0);
        chk("c6_rst_data", out_data, 0);
        @(negedge clk); rst = 1'b0;
        repeat (5) @(posedge clk);
        chk("c6_no_done", done_cnt - d0, 0);
        out_ready = 1'b1;
        push_exp(32'h12FF3456, 3'd4, 1'b1);
        d0 = done_cnt;
        run_job(12'h010, 14'd5);
        wait_done("c6_rerun", d0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
